// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the single-clock flexible FIFO: read-mode constants
// and the threshold legality rule checked when the FIFO is elaborated.
package sync_fifo_pkg;

   localparam int FIFO_STD  = 0;  // registered read, data_valid pulses
   localparam int FIFO_FWFT = 1;  // first-word-fall-through, head word on data_out

   // Threshold legality: almost-full in 1..depth, almost-empty in 0..depth-1.
   function automatic bit thresh_ok(input int depth, input int afull, input int aempty);
      return (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Storage array for sync_fifo_flex: DEPTH x DATA_WIDTH, synchronous write,
// asynchronous read, no reset (contents are undefined until written).
module fifo_mem_2p #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   // Write port: one word per clock when enabled.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_flex.sv
// Single-clock FIFO with standard or first-word-fall-through read mode,
// programmable almost-full/almost-empty flags, fill level and sticky
// overflow/underflow errors. Capacity is DEPTH words in both modes; in FWFT
// mode the output register counts as one of those words.
//
// Request semantics: a write is accepted iff wr_en && !fifo_full, a read iff
// rd_en && !fifo_Mty, both judged on registered state at the clock edge (a
// read in the same cycle does not make room for a write while full). A
// request that is not accepted changes no data state and only sets the
// matching sticky error flag.
module sync_fifo_flex
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDR_WIDTH    = 4,
   parameter int FWFT          = FIFO_STD,
   parameter int AFULL_THRESH  = (1 << ADDR_WIDTH) - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  fifo_full,
   output logic                  fifo_Mty,
   output logic                  fifo_afull,
   output logic                  fifo_aempty,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic                  overflow,
   output logic                  underflow,
   input  logic                  clr_err
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_L  = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AFULL_L  = (ADDR_WIDTH+1)'(AFULL_THRESH);
   localparam logic [ADDR_WIDTH:0] AEMPTY_L = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
   localparam logic [ADDR_WIDTH:0] ONE_L    = (ADDR_WIDTH+1)'(1);

   if (!thresh_ok(DEPTH, AFULL_THRESH, AEMPTY_THRESH)) begin : g_bad_thresh
      $error("sync_fifo_flex: AFULL_THRESH/AEMPTY_THRESH out of legal range");
   end
   if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
      $error("sync_fifo_flex: FWFT must be FIFO_STD or FIFO_FWFT");
   end

   // Pointers carry one extra wrap bit; memory uses the low ADDR_WIDTH bits.
   logic [ADDR_WIDTH:0]   wr_ptr, rd_ptr;
   logic [ADDR_WIDTH:0]   level_nxt;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  wr_acc, rd_acc;
   logic                  mem_we, rd_adv;
   logic                  out_load_mem, out_load_in, out_clear;

   assign wr_acc = wr_en && !fifo_full;
   assign rd_acc = rd_en && !fifo_Mty;

   // Route accepted requests to memory / output register and compute the next level.
   always_comb begin
      mem_we       = wr_acc;
      rd_adv       = rd_acc;
      out_load_mem = 1'b0;
      out_load_in  = 1'b0;
      out_clear    = 1'b0;
      if (FWFT == FIFO_FWFT) begin
         // The output register is refillable when empty or popped this cycle.
         // Memory head has priority; a write bypasses memory only when both
         // the output register and memory would otherwise be empty.
         out_load_mem = (!data_valid || rd_acc) && (wr_ptr != rd_ptr);
         out_load_in  = (!data_valid || rd_acc) && (wr_ptr == rd_ptr) && wr_acc;
         out_clear    = rd_acc && !out_load_mem && !out_load_in;
         mem_we       = wr_acc && !out_load_in;
         rd_adv       = out_load_mem;
      end
      level_nxt = fill_level;
      if (wr_acc && !rd_acc)      level_nxt = fill_level + ONE_L;
      else if (rd_acc && !wr_acc) level_nxt = fill_level - ONE_L;
   end

   fifo_mem_2p #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_mem (
      .clk   (clk),
      .we    (mem_we),
      .waddr (wr_ptr[ADDR_WIDTH-1:0]),
      .wdata (data_in),
      .raddr (rd_ptr[ADDR_WIDTH-1:0]),
      .rdata (mem_rdata)
   );

   // Pointers, fill level and level-derived flags, all registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         fill_level  <= '0;
         fifo_full   <= 1'b0;
         fifo_Mty    <= 1'b1;
         fifo_afull  <= 1'b0;
         fifo_aempty <= 1'b1;
      end else begin
         if (mem_we) wr_ptr <= wr_ptr + ONE_L;
         if (rd_adv) rd_ptr <= rd_ptr + ONE_L;
         fill_level  <= level_nxt;
         fifo_full   <= (level_nxt == DEPTH_L);
         fifo_Mty    <= (level_nxt == '0);
         fifo_afull  <= (level_nxt >= AFULL_L);
         fifo_aempty <= (level_nxt <= AEMPTY_L);
      end
   end

   // Output stage: registered read (standard) or head-word register (FWFT).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= '0;
         data_valid <= 1'b0;
      end else if (FWFT == FIFO_FWFT) begin
         if (out_load_mem) begin
            data_out   <= mem_rdata;
            data_valid <= 1'b1;
         end else if (out_load_in) begin
            data_out   <= data_in;
            data_valid <= 1'b1;
         end else if (out_clear) begin
            data_valid <= 1'b0;
         end
      end else begin
         if (rd_acc) data_out <= mem_rdata;
         data_valid <= rd_acc;
      end
   end

   // Sticky error flags; a new error in the same cycle wins over clr_err.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= (wr_en && fifo_full) || (overflow && !clr_err);
         underflow <= (rd_en && fifo_Mty) || (underflow && !clr_err);
      end
   end

endmodule

// File: tb/tb_sync_fifo_flex.sv
// Bench for sync_fifo_flex: a standard-mode and an FWFT-mode instance share
// the same stimulus and are compared each cycle against a queue-based model.
module tb_sync_fifo_flex;
   import sync_fifo_pkg::*;

   localparam int DW    = 8;
   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          wr_en, rd_en, clr_err;
   logic [DW-1:0] data_in;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_dv, s_full, s_mty, s_afull, s_aempty, s_ovf, s_udf;
   logic          f_dv, f_full, f_mty, f_afull, f_aempty, f_ovf, f_udf;
   logic [AW:0]   s_level, f_level;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model: exp_q holds every word in the FIFO, head first.
   logic [DW-1:0] exp_q[$];
   logic          m_ovf, m_udf, m_s_dv;
   logic [DW-1:0] m_s_dout, m_f_dout;

   sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_STD)) u_std (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(s_dout), .data_valid(s_dv), .fifo_full(s_full), .fifo_Mty(s_mty),
      .fifo_afull(s_afull), .fifo_aempty(s_aempty), .fill_level(s_level),
      .overflow(s_ovf), .underflow(s_udf), .clr_err(clr_err)
   );

   sync_fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(FIFO_FWFT)) u_fwft (
      .clk(clk), .reset(reset), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
      .data_out(f_dout), .data_valid(f_dv), .fifo_full(f_full), .fifo_Mty(f_mty),
      .fifo_afull(f_afull), .fifo_aempty(f_aempty), .fill_level(f_level),
      .overflow(f_ovf), .underflow(f_udf), .clr_err(clr_err)
   );

   // Clock.
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      else n_pass++;
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_ovf    = 1'b0;
      m_udf    = 1'b0;
      m_s_dv   = 1'b0;
      m_s_dout = '0;
      m_f_dout = '0;
   endtask

   task automatic model_step(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
      bit full, empty;
      full  = (exp_q.size() == DEPTH);
      empty = (exp_q.size() == 0);
      m_ovf  = (w && full) || (m_ovf && !c);
      m_udf  = (r && empty) || (m_udf && !c);
      m_s_dv = 1'b0;
      if (r && !empty) begin
         m_s_dout = exp_q.pop_front();
         m_s_dv   = 1'b1;
      end
      if (w && !full) exp_q.push_back(d);
      // FWFT output shows the head word; it keeps its last value once empty.
      if (exp_q.size() > 0) m_f_dout = exp_q[0];
   endtask

   task automatic check_all();
      int lvl;
      lvl = exp_q.size();
      check("s_data_out",   32'(s_dout),   32'(m_s_dout));
      check("s_data_valid", 32'(s_dv),     32'(m_s_dv));
      check("s_full",       32'(s_full),   32'(lvl == DEPTH));
      check("s_empty",      32'(s_mty),    32'(lvl == 0));
      check("s_afull",      32'(s_afull),  32'(lvl >= DEPTH - 2));
      check("s_aempty",     32'(s_aempty), 32'(lvl <= 2));
      check("s_level",      32'(s_level),  32'(lvl));
      check("s_overflow",   32'(s_ovf),    32'(m_ovf));
      check("s_underflow",  32'(s_udf),    32'(m_udf));
      check("f_data_out",   32'(f_dout),   32'(m_f_dout));
      check("f_data_valid", 32'(f_dv),     32'(lvl > 0));
      check("f_full",       32'(f_full),   32'(lvl == DEPTH));
      check("f_empty",      32'(f_mty),    32'(lvl == 0));
      check("f_afull",      32'(f_afull),  32'(lvl >= DEPTH - 2));
      check("f_aempty",     32'(f_aempty), 32'(lvl <= 2));
      check("f_level",      32'(f_level),  32'(lvl));
      check("f_overflow",   32'(f_ovf),    32'(m_ovf));
      check("f_underflow",  32'(f_udf),    32'(m_udf));
   endtask

   // Driver: apply one cycle of requests, advance the model at the edge, check 1ns later.
   task automatic step(input logic w, input logic r, input logic [DW-1:0] d, input logic c);
      wr_en   = w;
      rd_en   = r;
      data_in = d;
      clr_err = c;
      @(posedge clk);
      model_step(w, r, d, c);
      #1;
      check_all();
   endtask

   initial begin
      reset   = 1'b1;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      clr_err = 1'b0;
      data_in = '0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check_all();

      // Fill 16 words, then one write too many.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
      step(1'b1, 1'b0, 8'hFF, 1'b0);
      // Drain in order.
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b0);
      // Read while empty, then clear errors.
      step(1'b0, 1'b1, 8'h00, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);

      // Level 8, then 40 cycles of simultaneous read/write.
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
      for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

      // Single write to empty, then pop.
      step(1'b1, 1'b0, 8'hA5, 1'b0);
      step(1'b0, 1'b1, 8'h00, 1'b0);

      // Fill, then pop+write while full: write rejected.
      for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, 8'($urandom), 1'b0);
      step(1'b1, 1'b1, 8'h3C, 1'b0);
      step(1'b0, 1'b0, 8'h00, 1'b1);
      for (int i = 0; i < DEPTH - 1; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

      // Randomized traffic: write-heavy, then read-heavy, with occasional clears.
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) == 0),
              8'($urandom), 1'($urandom_range(0, 15) == 0));
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) != 0),
              8'($urandom), 1'($urandom_range(0, 15) == 0));
      for (int i = 0; i < 200; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              8'($urandom), 1'($urandom_range(0, 15) == 0));

      // Bring level to 10, then reset asynchronously mid-burst.
      for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b0);
      wr_en   = 1'b1;
      data_in = 8'h77;
      #3;
      reset = 1'b1;
      wr_en = 1'b0;
      #1;
      model_reset();
      check_all();
      @(posedge clk);
      #1;
      reset = 1'b0;
      check_all();

      // Only new data comes back after the reset.
      step(1'b1, 1'b0, 8'hC1, 1'b0);
      step(1'b1, 1'b0, 8'hC2, 1'b0);
      step(1'b1, 1'b0, 8'hC3, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
